// File: rtl/txb_sched_pkg.sv
// Shared types and sizing for the TXB scheduler slice.
// Pool geometry lives here so the interface, arbiter users and top agree on widths.
package txb_sched_pkg;

    localparam int NCORES      = 2;
    localparam int NTXBS       = 2;
    localparam int NMEMS       = 2;
    localparam int TXB_ADDR_W  = (NTXBS > 1) ? $clog2(NTXBS) : 1;
    localparam int MEM_ADDR_W  = (NMEMS > 1) ? $clog2(NMEMS) : 1;
    localparam int CORE_ADDR_W = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int CNT_W       = $clog2(NTXBS + 1);

    typedef struct packed {
        logic                   valid;
        logic [CORE_ADDR_W-1:0] core;
    } owner_t;

    typedef logic [CNT_W-1:0] sched_cnt_t;

    function automatic logic [TXB_ADDR_W-1:0] txb_index(input logic [NTXBS-1:0] oh);
        logic [TXB_ADDR_W-1:0] idx;
        idx = '0;
        for (int t = 0; t < NTXBS; t++) begin
            if (oh[t]) idx = TXB_ADDR_W'(t);
        end
        return idx;
    endfunction

endpackage

// File: rtl/txb_sched_if.sv
// Status/handshake bundle between the TXB pool side and the scheduler.
interface txb_sched_if;
    import txb_sched_pkg::*;

    logic [NCORES-1:0]            core_req;
    logic [NCORES-1:0]            core_rel;
    logic [NCORES-1:0]            core_acq;
    logic [NCORES-1:0]            core_hs;
    logic [NTXBS-1:0]             txb_free;
    logic [NTXBS-1:0]             txb_done;
    logic [NTXBS-1:0]             txb_mem_req;
    logic [NTXBS*MEM_ADDR_W-1:0]  txb_mem_addr;
    logic [NMEMS-1:0]             mem_xfer;
    logic [NCORES-1:0]            alloc_vld;
    logic [NCORES*TXB_ADDR_W-1:0] alloc_txb;
    logic [NMEMS*NTXBS-1:0]       mem_gnt;
    logic [NCORES*CNT_W-1:0]      core_outst;
    logic [NCORES-1:0]            core_blk;

    modport master (
        output core_req, core_rel, core_acq, core_hs,
        output txb_free, txb_done, txb_mem_req, txb_mem_addr, mem_xfer,
        input  alloc_vld, alloc_txb, mem_gnt, core_outst, core_blk
    );

    modport slave (
        input  core_req, core_rel, core_acq, core_hs,
        input  txb_free, txb_done, txb_mem_req, txb_mem_addr, mem_xfer,
        output alloc_vld, alloc_txb, mem_gnt, core_outst, core_blk
    );

endinterface

// File: rtl/txb_sched_rr_arb.sv
// Round-robin picker: first requester at or after ptr wins, as a one-hot grant.
module rr_arb #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any
);

    always_comb begin
        int idx;
        gnt = '0;
        any = 1'b0;
        idx = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/txb_sched.sv
// Shares the TXB pool: round-robin TXB allocation to cores, per-core acquire/release
// ordering, and locked round-robin arbitration of each memory port among TXBs.
module txb_sched
    import txb_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    txb_sched_if.slave bus
);

    owner_t                 owner       [NTXBS];
    owner_t                 owner_nxt   [NTXBS];
    logic [NCORES-1:0]      acq_pend, acq_pend_nxt;
    logic [TXB_ADDR_W-1:0]  acq_txb     [NCORES];
    logic [TXB_ADDR_W-1:0]  acq_txb_nxt [NCORES];
    logic [CORE_ADDR_W-1:0] core_ptr, core_ptr_nxt;
    sched_cnt_t             outst       [NCORES];
    sched_cnt_t             outst_nxt   [NCORES];
    logic [TXB_ADDR_W-1:0]  mem_ptr     [NMEMS];
    logic [TXB_ADDR_W-1:0]  mem_win     [NMEMS];
    logic [NMEMS-1:0]       mem_lock;

    logic [NTXBS-1:0]       owned, txb_elig, retire;
    logic [NCORES-1:0]      blk, core_elig, core_first, alloc_vld, commit;
    logic                   core_any;
    logic [TXB_ADDR_W-1:0]  alloc_idx   [NCORES];
    int                     start_core;
    logic [NTXBS-1:0]       arb_gnt     [NMEMS];
    logic [NMEMS-1:0]       arb_any;
    logic [NTXBS-1:0]       mem_gnt_c   [NMEMS];
    logic [TXB_ADDR_W-1:0]  mem_cur     [NMEMS];
    logic [NMEMS-1:0]       gnt_col     [NTXBS];

    // A retiring TXB stays owned until the edge, so it cannot be handed out in the same cycle.
    always_comb begin
        for (int t = 0; t < NTXBS; t++) owned[t] = owner[t].valid;
        for (int i = 0; i < NCORES; i++) blk[i] = acq_pend[i] | (bus.core_rel[i] && outst[i] != '0);
    end

    assign txb_elig  = bus.txb_free & ~owned;
    assign core_elig = bus.core_req & ~blk;
    assign retire    = bus.txb_done & owned;
    assign commit    = bus.core_hs & alloc_vld;

    rr_arb #(.N(NCORES)) u_core_arb (.req(core_elig), .ptr(core_ptr), .gnt(core_first), .any(core_any));

    always_comb begin
        logic [NTXBS-1:0] taken;
        logic             found;
        int               c;
        taken      = '0;
        found      = 1'b0;
        c          = 0;
        alloc_vld  = '0;
        alloc_idx  = '{default: '0};
        start_core = int'(core_ptr);
        for (int i = 0; i < NCORES; i++) begin
            if (core_any && core_first[i]) start_core = i;
        end
        for (int k = 0; k < NCORES; k++) begin
            c     = (start_core + k) % NCORES;
            found = 1'b0;
            for (int t = 0; t < NTXBS; t++) begin
                if (core_elig[c] && !found && txb_elig[t] && !taken[t]) begin
                    found        = 1'b1;
                    taken[t]     = 1'b1;
                    alloc_vld[c] = 1'b1;
                    alloc_idx[c] = TXB_ADDR_W'(t);
                end
            end
        end
    end

    always_comb begin
        int c, d;
        owner_nxt    = owner;
        acq_pend_nxt = acq_pend;
        acq_txb_nxt  = acq_txb;
        core_ptr_nxt = core_ptr;
        c            = 0;
        d            = 0;
        for (int t = 0; t < NTXBS; t++) begin
            if (retire[t]) begin
                owner_nxt[t].valid = 1'b0;
                if (acq_txb[owner[t].core] == TXB_ADDR_W'(t)) acq_pend_nxt[owner[t].core] = 1'b0;
            end
        end
        for (int i = 0; i < NCORES; i++) begin
            if (commit[i]) begin
                owner_nxt[alloc_idx[i]] = '{valid: 1'b1, core: CORE_ADDR_W'(i)};
                if (bus.core_acq[i]) begin
                    acq_pend_nxt[i] = 1'b1;
                    acq_txb_nxt[i]  = alloc_idx[i];
                end
            end
        end
        for (int k = 0; k < NCORES; k++) begin
            c = (start_core + k) % NCORES;
            if (commit[c]) core_ptr_nxt = CORE_ADDR_W'((c + 1) % NCORES);
        end
        for (int i = 0; i < NCORES; i++) begin
            d = 0;
            for (int t = 0; t < NTXBS; t++) begin
                if (retire[t] && int'(owner[t].core) == i) d++;
            end
            outst_nxt[i] = sched_cnt_t'(int'(outst[i]) + int'(commit[i]) - d);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner    <= '{default: '0};
            acq_pend <= '0;
            acq_txb  <= '{default: '0};
            outst    <= '{default: '0};
            core_ptr <= '0;
        end else begin
            owner    <= owner_nxt;
            acq_pend <= acq_pend_nxt;
            acq_txb  <= acq_txb_nxt;
            outst    <= outst_nxt;
            core_ptr <= core_ptr_nxt;
        end
    end

    for (genvar m = 0; m < NMEMS; m++) begin : g_mem
        logic [NTXBS-1:0] mreq;
        always_comb begin
            for (int t = 0; t < NTXBS; t++)
                mreq[t] = bus.txb_mem_req[t] && (bus.txb_mem_addr[t*MEM_ADDR_W +: MEM_ADDR_W] == MEM_ADDR_W'(m));
        end
        rr_arb #(.N(NTXBS)) u_mem_arb (.req(mreq), .ptr(mem_ptr[m]), .gnt(arb_gnt[m]), .any(arb_any[m]));
        assign mem_cur[m]   = mem_lock[m] ? mem_win[m] : txb_index(arb_gnt[m]);
        assign mem_gnt_c[m] = mem_lock[m] ? (NTXBS'(1) << mem_win[m]) : arb_gnt[m];

        a_lock_req: assert property (@(posedge clk) disable iff (!rst) mem_lock[m] |-> bus.txb_mem_req[mem_win[m]]);
    end

    // A transfer in the grant cycle itself releases the port without ever locking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_lock <= '0;
            mem_ptr  <= '{default: '0};
            mem_win  <= '{default: '0};
        end else begin
            for (int m = 0; m < NMEMS; m++) begin
                if ((mem_lock[m] || arb_any[m]) && bus.mem_xfer[m]) begin
                    mem_lock[m] <= 1'b0;
                    mem_ptr[m]  <= TXB_ADDR_W'((int'(mem_cur[m]) + 1) % NTXBS);
                end else if (!mem_lock[m] && arb_any[m]) begin
                    mem_lock[m] <= 1'b1;
                    mem_win[m]  <= mem_cur[m];
                end
            end
        end
    end

    always_comb begin
        for (int t = 0; t < NTXBS; t++)
            for (int m = 0; m < NMEMS; m++) gnt_col[t][m] = mem_gnt_c[m][t];
    end

    always_comb begin
        bus.alloc_vld  = rst ? alloc_vld : '0;
        bus.core_blk   = rst ? blk : '0;
        bus.alloc_txb  = '0;
        bus.core_outst = '0;
        bus.mem_gnt    = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (rst) begin
                bus.alloc_txb[i*TXB_ADDR_W +: TXB_ADDR_W] = alloc_idx[i];
                bus.core_outst[i*CNT_W +: CNT_W]          = outst[i];
            end
        end
        for (int m = 0; m < NMEMS; m++) begin
            if (rst) bus.mem_gnt[m*NTXBS +: NTXBS] = mem_gnt_c[m];
        end
    end

    a_hs_alloc: assert property (@(posedge clk) disable iff (!rst) (bus.core_hs & ~alloc_vld) == '0);
    a_done_owned: assert property (@(posedge clk) disable iff (!rst) (bus.txb_done & ~owned) == '0);

    for (genvar i = 0; i < NCORES; i++) begin : g_cnt_chk
        a_cnt_max: assert property (@(posedge clk) disable iff (!rst) outst[i] <= sched_cnt_t'(NTXBS));
    end

    for (genvar t = 0; t < NTXBS; t++) begin : g_col_chk
        a_col_excl: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt_col[t]));
    end

endmodule

// File: tb/tb_txb_sched.sv
// Directed bench for txb_sched: allocation order, ordering blocks, memory locking, reset.
module tb_txb_sched;
    import txb_sched_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    txb_sched_if bus();

    txb_sched dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well away from posedge.
    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] rel, input logic [1:0] acq,
                                 input logic [1:0] hs, input logic [1:0] free, input logic [1:0] done,
                                 input logic [1:0] mreq, input logic [1:0] maddr, input logic [1:0] xfer);
        @(negedge clk);
        bus.core_req     = req;
        bus.core_rel     = rel;
        bus.core_acq     = acq;
        bus.core_hs      = hs;
        bus.txb_free     = free;
        bus.txb_done     = done;
        bus.txb_mem_req  = mreq;
        bus.txb_mem_addr = maddr;
        bus.mem_xfer     = xfer;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b0;
        bus.core_req     = '0;
        bus.core_rel     = '0;
        bus.core_acq     = '0;
        bus.core_hs      = '0;
        bus.txb_free     = '0;
        bus.txb_done     = '0;
        bus.txb_mem_req  = '0;
        bus.txb_mem_addr = '0;
        bus.mem_xfer     = '0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_alloc_vld", 32'(bus.alloc_vld), 32'h0);
        checkOutput("rst_mem_gnt", 32'(bus.mem_gnt), 32'h0);
        checkOutput("rst_outst", 32'(bus.core_outst), 32'h0);
        checkOutput("rst_blk", 32'(bus.core_blk), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Round-robin allocation: both cores, only core0 accepts, then core1 wins contention.
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        checkOutput("rr_both_vld", 32'(bus.alloc_vld), 32'h3);
        checkOutput("rr_both_txb", 32'(bus.alloc_txb), 32'h2);
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        checkOutput("rr_outst_c0", 32'(bus.core_outst), 32'h1);
        checkOutput("rr_contend_vld", 32'(bus.alloc_vld), 32'h2);
        checkOutput("rr_contend_txb", 32'(bus.alloc_txb), 32'h2);

        // Release write blocked while core0 has a TX in flight.
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
        checkOutput("outst_both", 32'(bus.core_outst), 32'h5);
        applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00);
        checkOutput("rel_outst", 32'(bus.core_outst), 32'h1);
        checkOutput("rel_blk", 32'(bus.core_blk), 32'h1);
        checkOutput("rel_no_alloc", 32'(bus.alloc_vld), 32'h0);
        applyStimulus(2'b01, 2'b01, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        checkOutput("rel_drained_outst", 32'(bus.core_outst), 32'h0);
        checkOutput("rel_unblk", 32'(bus.core_blk), 32'h0);
        checkOutput("rel_alloc_vld", 32'(bus.alloc_vld), 32'h1);
        checkOutput("rel_alloc_txb", 32'(bus.alloc_txb), 32'h0);

        // Core1 acquire read blocks core1 only until its TXB retires.
        applyStimulus(2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        checkOutput("acq_outst", 32'(bus.core_outst), 32'h1);
        checkOutput("acq_vld", 32'(bus.alloc_vld), 32'h2);
        checkOutput("acq_txb", 32'(bus.alloc_txb), 32'h2);
        applyStimulus(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        checkOutput("acq_outst2", 32'(bus.core_outst), 32'h5);
        checkOutput("acq_blk", 32'(bus.core_blk), 32'h2);
        checkOutput("acq_no_alloc", 32'(bus.alloc_vld), 32'h0);
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        checkOutput("acq_outst3", 32'(bus.core_outst), 32'h4);
        checkOutput("acq_blk_c1_only", 32'(bus.core_blk), 32'h2);
        checkOutput("acq_c0_vld", 32'(bus.alloc_vld), 32'h1);
        checkOutput("acq_c0_txb", 32'(bus.alloc_txb), 32'h0);
        applyStimulus(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
        checkOutput("acq_blk_held", 32'(bus.core_blk), 32'h2);
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        checkOutput("acq_cleared_outst", 32'(bus.core_outst), 32'h0);
        checkOutput("acq_cleared_blk", 32'(bus.core_blk), 32'h0);
        checkOutput("acq_cleared_vld", 32'(bus.alloc_vld), 32'h3);
        checkOutput("acq_cleared_txb", 32'(bus.alloc_txb), 32'h2);

        // Memory 0 locked on TXB0 until a transfer, then round-robin moves to TXB1.
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        checkOutput("mem_gnt_c1", 32'(bus.mem_gnt), 32'h1);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        checkOutput("mem_gnt_c2", 32'(bus.mem_gnt), 32'h1);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        checkOutput("mem_gnt_c3", 32'(bus.mem_gnt), 32'h1);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b01);
        checkOutput("mem_gnt_xfer", 32'(bus.mem_gnt), 32'h1);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        checkOutput("mem_gnt_rr_txb1", 32'(bus.mem_gnt), 32'h2);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01);
        checkOutput("mem_gnt_txb1_held", 32'(bus.mem_gnt), 32'h2);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b11);
        checkOutput("mem_gnt_split", 32'(bus.mem_gnt), 32'h6);

        // Same-cycle retire and accept on core0 keeps the counter; retired TXB0 free a cycle later.
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        checkOutput("same_first_vld", 32'(bus.alloc_vld), 32'h1);
        checkOutput("same_first_txb", 32'(bus.alloc_txb), 32'h0);
        checkOutput("same_mem_idle", 32'(bus.mem_gnt), 32'h0);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00);
        checkOutput("same_outst_before", 32'(bus.core_outst), 32'h1);
        checkOutput("same_vld", 32'(bus.alloc_vld), 32'h1);
        checkOutput("same_txb_not0", 32'(bus.alloc_txb), 32'h1);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        checkOutput("same_outst_after", 32'(bus.core_outst), 32'h1);
        checkOutput("same_next_vld", 32'(bus.alloc_vld), 32'h1);
        checkOutput("same_next_txb0", 32'(bus.alloc_txb), 32'h0);

        // Reset mid-operation with an owned TXB and a locked memory.
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        checkOutput("pre_rst_lock", 32'(bus.mem_gnt), 32'h1);
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00);
        checkOutput("pre_rst_gnt", 32'(bus.mem_gnt), 32'h1);
        checkOutput("pre_rst_outst", 32'(bus.core_outst), 32'h1);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_vld", 32'(bus.alloc_vld), 32'h0);
        checkOutput("mid_rst_gnt", 32'(bus.mem_gnt), 32'h0);
        checkOutput("mid_rst_outst", 32'(bus.core_outst), 32'h0);
        checkOutput("mid_rst_blk", 32'(bus.core_blk), 32'h0);
        bus.core_req    = '0;
        bus.txb_free    = '0;
        bus.txb_mem_req = '0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(2'b10, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00);
        checkOutput("post_rst_vld", 32'(bus.alloc_vld), 32'h2);
        checkOutput("post_rst_txb", 32'(bus.alloc_txb), 32'h0);
        checkOutput("post_rst_gnt", 32'(bus.mem_gnt), 32'h2);
        checkOutput("post_rst_outst", 32'(bus.core_outst), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/txb_sched.md
Name: txb_sched

Overview:
Registered scheduler that shares the TXB pool between cores and memories. It replaces fixed-priority TXB selection with round-robin allocation of free TXBs to requesting cores. It arbitrates each memory port among the TXBs addressing it, with the grant held until the transfer handshake completes. It enforces per-core acquire/release ordering. It sits beside the TXB pool: it observes TXB status and link handshakes and drives the select signals the pool's muxes consume.

Parameters:
NCORES, 2, number of cores
NTXBS, 2, number of TXBs
NMEMS, 2, number of memories
CNT_W, $clog2(NTXBS+1), width of per-core outstanding counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
core_req  in  NCORES  core i src_rdy on cores2wpath
core_rel  in  NCORES  core i TX is acq_rel && kind==TX_WR
core_acq  in  NCORES  core i TX is acq_rel && kind==TX_RD
core_hs  in  NCORES  core i src_rdy&&tgt_rdy (TX accepted)
txb_free  in  NTXBS  txb_status==TXB_STATUS_FREE
txb_done  in  NTXBS  TXB→core response handshake completed (TXB retires)
txb_mem_req  in  NTXBS  TXB in TXB_STATUS_CORE2TXB, presenting a TX
txb_mem_addr  in  NTXBS*MEM_ADDR_W  target memory per TXB
mem_xfer  in  NMEMS  rpath2mems src_rdy&&tgt_rdy
alloc_vld  out  NCORES  core i granted a TXB this cycle
alloc_txb  out  NCORES*TXB_ADDR_W  TXB index granted to core i
mem_gnt  out  NMEMS*NTXBS  one-hot TXB owning memory m
core_outst  out  NCORES*CNT_W  TXs in flight per core
core_blk  out  NCORES  core i held off by ordering rule

Behaviour:
- Reset (rst low, async): owner[] invalid, acq_pend=0, core/mem RR pointers=0, mem locks clear, counters=0. All outputs 0.
- Grants are combinational from registered state plus the current-cycle inputs. State updates on posedge clk.
- TXB eligible: txb_free[t] && !owned[t]. owned[t] is set on the core_hs that consumed a grant and cleared on txb_done[t].
- Core eligible: core_req[i] && !core_blk[i].
- core_blk[i] is 1 when acq_pend[i] is set, or when core_rel[i] && core_outst[i]!=0.
- Allocation:
  - Iterate cores round-robin from the core pointer.
  - Each eligible core gets the lowest-index eligible TXB not already given to another core this cycle.
  - A core gets at most one TXB; a TXB goes to at most one core.
- Commit: on core_hs[i] with alloc_vld[i]:
  - owner[alloc_txb[i]] ← i.
  - core_outst[i]++.
  - If core_acq[i], set acq_pend[i] and record the TXB.
  - Core pointer ← i+1 mod NCORES (last committed core in the RR order).
- core_hs[i] without alloc_vld[i] is a protocol error: assertion fails, no state change.
- Retire: txb_done[t] for an owned TXB:
  - core_outst[owner]--.
  - Clear acq_pend[owner] if t is its recorded acquire TXB.
  - Clear owned[t].
  - Done on an unowned TXB: ignored, assertion fails.
- Same-cycle increment and decrement on one core: counter unchanged.
- Counter never exceeds NTXBS (assert).
- A TXB retiring this cycle is not reallocatable until the next cycle.
- Memory arbitration (per m):
  - Requesters: TXBs with txb_mem_req && addr==m.
  - If unlocked, grant the RR winner from the mem pointer, set lock and latch the winner.
  - While locked, mem_gnt[m] stays on the latched TXB even if its req drops (assert req stays high).
  - On mem_xfer[m]: unlock, pointer ← winner+1 mod NTXBS. A new grant is possible in the next cycle.
- A TXB is granted to at most one memory; mem_gnt columns are mutually exclusive (assert).
- Release rule ⇒ a release write never enters a TXB while an earlier TX from the same core is in flight. This satisfies pool-level sync correctness.

Decomposition:
- txb_defs: TXB_ADDR_W, MEM_ADDR_W, CORE_ADDR_W (existing), owner_t {valid, core}, sched_cnt_t.
- Sub-module rr_arb #(N): req[N], ptr → one-hot gnt, any. Instantiated once for core allocation order and NMEMS times for memories.

Test Plan:
- Reset mid-operation: owners set, mem locked, rst low → all outputs 0 asynchronously; after release, the first request from core 1 gets TXB 0.
- Both cores request, both TXBs free, ptr=0 → core0→TXB0, core1→TXB1. Next contention with one free TXB goes to core1 (ptr advanced).
- Core0 issues a write (outst=1), then a release write → core_blk[0]=1, no alloc. txb_done for that TXB → next cycle alloc_vld[0]=1.
- Core1 acquire read accepted → any further core1 request blocked until that TXB's txb_done; core0 unaffected.
- TXB0 and TXB1 both target mem 0 → mem_gnt[0]=TXB0 held 3 cycles without mem_xfer. After xfer, TXB1 is granted the next cycle.
- Same cycle: txb_done[0] (core0) and core_hs[0] on TXB1 → core_outst[0] stays 1; TXB0 not granted that cycle, granted the following one.
